// File: rtl/zeus_alu_pkg.sv
// Shared definitions for the ALU control sequencer: funct/control codes,
// sequencer states and op classes.
package zeus_alu_pkg;

    localparam logic [5:0] F_ADD  = 6'b000000;
    localparam logic [5:0] F_ADDU = 6'b000001;
    localparam logic [5:0] F_AND  = 6'b000010;
    localparam logic [5:0] F_DIV  = 6'b000011;
    localparam logic [5:0] F_DIVU = 6'b000100;
    localparam logic [5:0] F_MULT = 6'b000101;
    localparam logic [5:0] F_NOR  = 6'b000110;
    localparam logic [5:0] F_XOR  = 6'b000111;
    localparam logic [5:0] F_OR   = 6'b001000;
    localparam logic [5:0] F_SLT  = 6'b001001;
    localparam logic [5:0] F_SUB  = 6'b001010;
    localparam logic [5:0] F_SUBU = 6'b001011;
    localparam logic [5:0] F_SLL  = 6'b001100;
    localparam logic [5:0] F_SRL  = 6'b001101;
    localparam logic [5:0] F_SLTU = 6'b001110;

    localparam logic [5:0] C_ADD  = 6'b000000;
    localparam logic [5:0] C_AND  = 6'b000001;
    localparam logic [5:0] C_DIV  = 6'b000010;
    localparam logic [5:0] C_MULT = 6'b000011;
    localparam logic [5:0] C_SUB  = 6'b000100;
    localparam logic [5:0] C_OR   = 6'b000101;
    localparam logic [5:0] C_NOR  = 6'b000110;
    localparam logic [5:0] C_XOR  = 6'b000111;
    localparam logic [5:0] C_SLT  = 6'b001000;
    localparam logic [5:0] C_SLL  = 6'b001001;
    localparam logic [5:0] C_SRL  = 6'b001010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULTI = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2
    } op_class_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational Funct/ALUOp/Sinal decoder. ALU_CTRL_SHIFT_EN adds the
// sll/srl/sltu codes; without it those codes decode as illegal.
module alu_funct_decode
    import zeus_alu_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int CTRL_W  = 6
) (
    input  logic [FUNCT_W-1:0] funct,
    input  logic               alu_op,
    input  logic [CTRL_W-1:0]  sinal,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               is_unsigned,
    output op_class_t          op_class,
    output logic               illegal
);

    always_comb begin
        ctrl        = '0;
        is_unsigned = 1'b0;
        op_class    = SINGLE;
        illegal     = 1'b0;
        if (!alu_op) begin
            ctrl = sinal;
        end else begin
            case (funct)
                FUNCT_W'(F_ADD):  ctrl = CTRL_W'(C_ADD);
                FUNCT_W'(F_ADDU): begin ctrl = CTRL_W'(C_ADD);  is_unsigned = 1'b1; end
                FUNCT_W'(F_AND):  ctrl = CTRL_W'(C_AND);
                FUNCT_W'(F_DIV):  begin ctrl = CTRL_W'(C_DIV);  op_class = DIV; end
                FUNCT_W'(F_DIVU): begin ctrl = CTRL_W'(C_DIV);  op_class = DIV; is_unsigned = 1'b1; end
                FUNCT_W'(F_MULT): begin ctrl = CTRL_W'(C_MULT); op_class = MUL; end
                FUNCT_W'(F_NOR):  ctrl = CTRL_W'(C_NOR);
                FUNCT_W'(F_XOR):  ctrl = CTRL_W'(C_XOR);
                FUNCT_W'(F_OR):   ctrl = CTRL_W'(C_OR);
                FUNCT_W'(F_SLT):  ctrl = CTRL_W'(C_SLT);
                FUNCT_W'(F_SUB):  ctrl = CTRL_W'(C_SUB);
                FUNCT_W'(F_SUBU): begin ctrl = CTRL_W'(C_SUB);  is_unsigned = 1'b1; end
`ifdef ALU_CTRL_SHIFT_EN
                FUNCT_W'(F_SLL):  ctrl = CTRL_W'(C_SLL);
                FUNCT_W'(F_SRL):  ctrl = CTRL_W'(C_SRL);
                FUNCT_W'(F_SLTU): begin ctrl = CTRL_W'(C_SLT);  is_unsigned = 1'b1; end
`endif
                default:          illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a mult/div sequencer (Busy/Done/Flush).
//
//   state | meaning
//   IDLE  | no op in flight, waiting for an accept
//   MULTI | multi-cycle op counting down, Busy high
//   DONE  | one-cycle Done pulse; may accept the next op directly
module alu_control_seq
    import zeus_alu_pkg::*;
#(
    parameter int FUNCT_W    = 6,
    parameter int CTRL_W     = 6,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               Valid,
    input  logic               Flush,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic               ALUOp,
    input  logic [CTRL_W-1:0]  Sinal,
    output logic [CTRL_W-1:0]  Controle,
    output logic               Unsigned,
    output logic               Busy,
    output logic               Done,
    output logic               Illegal
);

    localparam int MAX_CYCLES = max_int(MUL_CYCLES, DIV_CYCLES);
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_unsigned;
    op_class_t         dec_class;
    logic              dec_illegal;

    alu_funct_decode #(
        .FUNCT_W (FUNCT_W),
        .CTRL_W  (CTRL_W)
    ) u_decode (
        .funct       (Funct),
        .alu_op      (ALUOp),
        .sinal       (Sinal),
        .ctrl        (dec_ctrl),
        .is_unsigned (dec_unsigned),
        .op_class    (dec_class),
        .illegal     (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Valid && !Flush) begin
                    accept = 1'b1;
                    case (dec_class)
                        MUL:     begin state_d = MULTI; cnt_d = MUL_LOAD; end
                        DIV:     begin state_d = MULTI; cnt_d = DIV_LOAD; end
                        default: state_d = DONE;
                    endcase
                end
            end
            MULTI: begin
                // Flush aborts silently; the control word keeps its last value
                if (Flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            Controle <= '0;
            Unsigned <= 1'b0;
            Illegal  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                Controle <= dec_ctrl;
                Unsigned <= dec_unsigned;
                Illegal  <= dec_illegal;
            end
        end
    end

    assign Busy = (state_q == MULTI);
    assign Done = (state_q == DONE);

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq with a Done-driven scoreboard;
// expectations follow ALU_CTRL_SHIFT_EN when it is defined.
module tb_alu_control_seq;

    logic       clock = 1'b0;
    logic       reset;
    logic       Valid;
    logic       Flush;
    logic [5:0] Funct;
    logic       ALUOp;
    logic [5:0] Sinal;
    logic [5:0] Controle;
    logic       Unsigned;
    logic       Busy;
    logic       Done;
    logic       Illegal;

    typedef struct packed {
        logic [5:0] ctrl;
        logic       uns;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;
    int   d0;

    alu_control_seq #(
        .FUNCT_W    (6),
        .CTRL_W     (6),
        .MUL_CYCLES (4),
        .DIV_CYCLES (32)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .Valid    (Valid),
        .Flush    (Flush),
        .Funct    (Funct),
        .ALUOp    (ALUOp),
        .Sinal    (Sinal),
        .Controle (Controle),
        .Unsigned (Unsigned),
        .Busy     (Busy),
        .Done     (Done),
        .Illegal  (Illegal)
    );

    always #5 clock = ~clock;

    function automatic exp_t ref_model(input logic aluop, input logic [5:0] f, input logic [5:0] s);
        exp_t e;
        e = '0;
        if (!aluop) begin
            e.ctrl = s;
        end else begin
            case (f)
                6'h00: e.ctrl = 6'h00;
                6'h01: begin e.ctrl = 6'h00; e.uns = 1'b1; end
                6'h02: e.ctrl = 6'h01;
                6'h03: e.ctrl = 6'h02;
                6'h04: begin e.ctrl = 6'h02; e.uns = 1'b1; end
                6'h05: e.ctrl = 6'h03;
                6'h06: e.ctrl = 6'h06;
                6'h07: e.ctrl = 6'h07;
                6'h08: e.ctrl = 6'h05;
                6'h09: e.ctrl = 6'h08;
                6'h0a: e.ctrl = 6'h04;
                6'h0b: begin e.ctrl = 6'h04; e.uns = 1'b1; end
`ifdef ALU_CTRL_SHIFT_EN
                6'h0c: e.ctrl = 6'h09;
                6'h0d: e.ctrl = 6'h0a;
                6'h0e: begin e.ctrl = 6'h08; e.uns = 1'b1; end
`endif
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic request(input logic aluop, input logic [5:0] f, input logic [5:0] s,
                           input bit expect_done);
        Valid = 1'b1;
        Flush = 1'b0;
        ALUOp = aluop;
        Funct = f;
        Sinal = s;
        if (expect_done) exp_q.push_back(ref_model(aluop, f, s));
    endtask

    // Scoreboard: every Done pulse must match the oldest outstanding request
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset === 1'b0 && Done === 1'b1) begin
            done_cnt++;
            chk("sb_done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_ctrl", 32'(Controle), 32'(e.ctrl));
                chk("sb_unsigned", 32'(Unsigned), 32'(e.uns));
                chk("sb_illegal", 32'(Illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        reset = 1'b1;
        Valid = 1'b0;
        Flush = 1'b0;
        ALUOp = 1'b0;
        Funct = 6'h00;
        Sinal = 6'h00;
        repeat (2) @(negedge clock);
        chk("rst_ctrl", 32'(Controle), 32'd0);
        chk("rst_unsigned", 32'(Unsigned), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_illegal", 32'(Illegal), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // subu: single cycle, unsigned
        request(1'b1, 6'h0b, 6'h00, 1'b1);
        @(negedge clock);
        chk("subu_done", 32'(Done), 32'd1);
        chk("subu_busy", 32'(Busy), 32'd0);
        chk("subu_ctrl", 32'(Controle), 32'h04);
        chk("subu_unsigned", 32'(Unsigned), 32'd1);
        Valid = 1'b0;
        @(negedge clock);
        chk("subu_done_pulse", 32'(Done), 32'd0);

        // pass-through, Funct carries a div code that must be ignored
        request(1'b0, 6'h03, 6'h2a, 1'b1);
        @(negedge clock);
        chk("pass_done", 32'(Done), 32'd1);
        chk("pass_busy", 32'(Busy), 32'd0);
        chk("pass_ctrl", 32'(Controle), 32'h2a);
        chk("pass_illegal", 32'(Illegal), 32'd0);
        Valid = 1'b0;
        @(negedge clock);

        // mult: Busy for 4 cycles, add presented during Busy is ignored
        request(1'b1, 6'h05, 6'h00, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            chk("mul_busy", 32'(Busy), 32'd1);
            chk("mul_done_low", 32'(Done), 32'd0);
            chk("mul_ctrl_held", 32'(Controle), 32'h03);
            if (i == 1) begin
                Valid = 1'b1;
                ALUOp = 1'b1;
                Funct = 6'h00;
            end
            if (i == 3) Valid = 1'b0;
        end
        @(negedge clock);
        chk("mul_done", 32'(Done), 32'd1);
        chk("mul_busy_end", 32'(Busy), 32'd0);
        @(negedge clock);
        chk("mul_done_pulse", 32'(Done), 32'd0);
        chk("mul_add_ignored", 32'(Controle), 32'h03);

        // div flushed in its third Busy cycle
        request(1'b1, 6'h03, 6'h00, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            chk("div_busy", 32'(Busy), 32'd1);
            Valid = 1'b0;
            if (i == 3) Flush = 1'b1;
        end
        d0 = done_cnt;
        @(negedge clock);
        chk("flush_busy", 32'(Busy), 32'd0);
        chk("flush_done", 32'(Done), 32'd0);
        chk("flush_ctrl_kept", 32'(Controle), 32'h02);
        Flush = 1'b0;
        repeat (40) @(negedge clock);
        chk("flush_no_done", 32'(done_cnt), 32'(d0));
        request(1'b1, 6'h00, 6'h00, 1'b1);
        @(negedge clock);
        chk("post_flush_add_done", 32'(Done), 32'd1);
        chk("post_flush_add_ctrl", 32'(Controle), 32'h00);
        Valid = 1'b0;
        @(negedge clock);

        // Flush together with Valid: request dropped
        Valid = 1'b1;
        Flush = 1'b1;
        ALUOp = 1'b1;
        Funct = 6'h07;
        d0 = done_cnt;
        @(negedge clock);
        chk("flushvalid_done", 32'(Done), 32'd0);
        chk("flushvalid_ctrl", 32'(Controle), 32'h00);
        Valid = 1'b0;
        Flush = 1'b0;
        @(negedge clock);
        chk("flushvalid_no_done", 32'(done_cnt), 32'(d0));

        // optional shift code, then back-to-back accepts from DONE
        request(1'b1, 6'h0c, 6'h00, 1'b1);
        @(negedge clock);
        chk("sll_done", 32'(Done), 32'd1);
        chk("sll_illegal", 32'(Illegal), 32'(ref_model(1'b1, 6'h0c, 6'h00).ill));
        chk("sll_ctrl", 32'(Controle), 32'(ref_model(1'b1, 6'h0c, 6'h00).ctrl));
        request(1'b1, 6'h07, 6'h00, 1'b1);
        @(negedge clock);
        chk("b2b_xor_done", 32'(Done), 32'd1);
        chk("b2b_xor_ctrl", 32'(Controle), 32'h07);
        request(1'b1, 6'h3f, 6'h00, 1'b1);
        @(negedge clock);
        chk("b2b_bad_done", 32'(Done), 32'd1);
        chk("b2b_bad_illegal", 32'(Illegal), 32'd1);
        chk("b2b_bad_ctrl", 32'(Controle), 32'h00);
        request(1'b1, 6'h05, 6'h00, 1'b1);
        @(negedge clock);
        chk("b2b_mul_busy", 32'(Busy), 32'd1);
        chk("b2b_mul_illegal_clr", 32'(Illegal), 32'd0);
        Valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("b2b_mul_busy_last", 32'(Busy), 32'd1);
        @(negedge clock);
        chk("b2b_mul_done", 32'(Done), 32'd1);
        @(negedge clock);

        // reset in the middle of a divu
        request(1'b1, 6'h04, 6'h00, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            Valid = 1'b0;
        end
        chk("rstmid_busy_before", 32'(Busy), 32'd1);
        chk("rstmid_unsigned_before", 32'(Unsigned), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_ctrl", 32'(Controle), 32'd0);
        chk("rstmid_unsigned", 32'(Unsigned), 32'd0);
        chk("rstmid_busy", 32'(Busy), 32'd0);
        chk("rstmid_done", 32'(Done), 32'd0);
        chk("rstmid_illegal", 32'(Illegal), 32'd0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rstmid_idle_busy", 32'(Busy), 32'd0);
        chk("rstmid_no_done", 32'(done_cnt), 32'(d0));
        request(1'b1, 6'h01, 6'h00, 1'b1);
        @(negedge clock);
        chk("rstmid_addu_done", 32'(Done), 32'd1);
        chk("rstmid_addu_unsigned", 32'(Unsigned), 32'd1);
        Valid = 1'b0;
        repeat (2) @(negedge clock);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, parametrised successor to the processor's combinational ALU control decoder.
- Decodes Funct when ALUOp=1, or passes Sinal through when ALUOp=0, into the ALU control word.
- Adds signedness and illegal-funct flags.
- Sequences multi-cycle mult/div ops with Busy/Done handshaking. Busy stalls the pipeline; Flush aborts an op in flight.

Parameters:
- FUNCT_W, 6, width of Funct field.
- CTRL_W, 6, width of Sinal and Controle.
- MUL_CYCLES, 4, Busy cycles for mult (>=1).
- DIV_CYCLES, 32, Busy cycles for div/divu (>=1).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Valid  input  1  new request present this cycle.
- Flush  input  1  abort any op in flight; drop this cycle's request.
- Funct  input  FUNCT_W  R-type function field.
- ALUOp  input  1  1 = decode Funct; 0 = use Sinal.
- Sinal  input  CTRL_W  control word used directly when ALUOp=0.
- Controle  output  CTRL_W  registered ALU control word.
- Unsigned  output  1  registered: op is addu/subu/divu (or sltu with the option).
- Busy  output  1  multi-cycle op in progress; pipeline must stall.
- Done  output  1  one-cycle pulse: result of the accepted op is valid.
- Illegal  output  1  registered: ALUOp=1 and Funct is unmapped.

Behaviour:
- Reset (async, active-high): state IDLE, counter 0, Controle=0, Unsigned=0, Busy=0, Done=0, Illegal=0.
- Decode when ALUOp=1 (Funct -> Controle, Unsigned):
  - 000000 add -> 000000, 0
  - 000001 addu -> 000000, 1
  - 000010 and -> 000001, 0
  - 000011 div -> 000010, 0 (multi-cycle)
  - 000100 divu -> 000010, 1 (multi-cycle)
  - 000101 mult -> 000011, 0 (multi-cycle)
  - 000110 nor -> 000110, 0
  - 000111 xor -> 000111, 0
  - 001000 or -> 000101, 0
  - 001001 slt -> 001000, 0
  - 001010 sub -> 000100, 0
  - 001011 subu -> 000100, 1
  - Any other Funct -> Controle 000000, Unsigned 0, Illegal 1; treated as single-cycle.
- ALUOp=0: Controle=Sinal, Unsigned=0, Illegal=0, single-cycle. Funct is ignored.
- States:
  - IDLE: Busy=0, Done=0.
  - MULTI: Busy=1, counter active.
  - DONE: Done=1 for exactly one cycle.
- Accept: Valid=1 && Flush=0 in IDLE or DONE. Controle/Unsigned/Illegal are loaded at the accept edge and held until the next accept.
- Single-cycle op: accept edge -> DONE. Done is high in the cycle after the accept edge (latency 1).
- Multi-cycle op: accept edge -> MULTI, counter = N-1, where N = MUL_CYCLES or DIV_CYCLES.
  - Counter decrements each edge. At the edge where counter==0, go to DONE.
  - Busy is high for exactly N cycles; Done follows (latency N+1).
- DONE with no accept -> IDLE. DONE with accept -> next op (back-to-back, no bubble).
- Valid while in MULTI is ignored. The upstream stage holds the request under Busy.
- Flush in MULTI: next edge -> IDLE, Busy=0, no Done; Controle retains its last value.
- Flush with Valid: flush wins, request dropped. Flush in IDLE or DONE: -> IDLE.
- Reset asserted mid-op: immediate return to reset values; no Done.
- Counter width: clog2 of max(MUL_CYCLES, DIV_CYCLES), minimum 1.

Optional Feature:
- Macro ALU_CTRL_SHIFT_EN.
- Defined: adds Funct 001100 sll -> 001001; 001101 srl -> 001010; 001110 sltu -> 001000 with Unsigned=1. All three are single-cycle.
- Undefined: those codes decode as Illegal.

Decomposition:
- Package zeus_alu_pkg holds:
  - Funct code constants and Controle code constants.
  - State enum (IDLE, MULTI, DONE).
  - Op-class typedef (SINGLE, MUL, DIV).
- Sub-module alu_funct_decode: purely combinational, Funct/ALUOp/Sinal -> ctrl, unsigned, op-class, illegal.
- This block keeps the FSM, counter and output registers.

Test Plan:
- Reset mid-MULTI (div accepted, reset after 5 cycles) -> all outputs 0 immediately, state IDLE, no Done.
- Valid, ALUOp=1, Funct=001011 -> next cycle Controle=000100, Unsigned=1, Done=1, Busy=0.
- Valid, ALUOp=0, Sinal=101010 -> Controle=101010, Illegal=0, Done after 1 cycle.
- Valid, Funct=000101, MUL_CYCLES=4 -> Busy high exactly 4 cycles, Controle=000011 held, Done pulses in cycle 5. A Valid for an add during Busy is ignored.
- Div accepted, Flush in 3rd Busy cycle -> Busy low next cycle, Done never asserts. A following add is accepted normally.
- Funct=001100 -> without the macro: Illegal=1, Controle=000000. With ALU_CTRL_SHIFT_EN: Controle=001001, Illegal=0. Back-to-back Valid in DONE accepted with no idle cycle.
